// File: rtl/cache_pkg.sv
// Shared definitions for the cache request path: packed entry layout,
// bus widths and the memory-drain state encoding.
package cache_pkg;

   localparam int ADDR_WIDTH     = 32;
   localparam int DATA_WIDTH     = 32;
   localparam int DATA_BYTES     = DATA_WIDTH / 8;
   localparam int CPU_ADDR_BUF   = 2;
   localparam int CPU_ADDR_DEPTH = 1 << CPU_ADDR_BUF;

   // Entry layout, LSB first: LOAD, MODE, STRB, DATA, ADDR
   localparam int LOAD_LSB      = 0;
   localparam int MODE_LSB      = 1;
   localparam int STRB_LSB      = 2;
   localparam int STRB_MSB      = STRB_LSB + DATA_BYTES - 1;
   localparam int DATA_LSB      = STRB_MSB + 1;
   localparam int DATA_MSB      = DATA_LSB + DATA_WIDTH - 1;
   localparam int ADDR_LSB      = DATA_MSB + 1;
   localparam int ADDR_MSB      = ADDR_LSB + ADDR_WIDTH - 1;
   localparam int FIFO_WIDTH_EX = ADDR_MSB + 1;

   localparam int RSP_CNT_W = CPU_ADDR_BUF + 1;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
      logic [DATA_BYTES-1:0] strb;
      logic                  mode;
      logic                  load;
   } cache_entry_t;

   typedef enum logic [1:0] {
      DRAIN_IDLE,
      DRAIN_REQ,
      DRAIN_STALL
   } drain_state_e;

endpackage

// File: rtl/cache_tag_queue.sv
// One-bit-wide circular FIFO remembering, per outstanding read, whether the
// response belongs to a line fill (1) or a CPU read (0).
module cache_tag_queue #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic push_i,
   input  logic push_bit_i,
   input  logic pop_i,
   output logic head_bit_o,
   output logic empty_o,
   output logic full_o
);

   localparam int              CNT_W    = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [DEPTH-1:0] bits_reg;
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   assign empty_o    = (count_reg == '0);
   assign full_o     = (count_reg == FULL_CNT);
   assign head_bit_o = bits_reg[rd_ptr_reg];
   assign do_pop     = pop_i && !empty_o;
   assign do_push    = push_i && (!full_o || do_pop);

   // Storage needs no reset: the pointers/count define which bits are live.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         bits_reg[wr_ptr_reg] <= push_bit_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
         if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
         if (do_push && !do_pop)      count_reg <= count_reg + CNT_W'(1);
         else if (do_pop && !do_push) count_reg <= count_reg - CNT_W'(1);
      end
   end

endmodule

// File: rtl/cache_mem_drain.sv
// Pops packed cache requests, issues them on the memory valid/ready port and
// routes in-order read responses to the line-fill or CPU read-data path.
module cache_mem_drain
   import cache_pkg::*;
#(
   parameter int FIFO_W   = FIFO_WIDTH_EX,
   parameter int RD_DEPTH = CPU_ADDR_DEPTH
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  fifo_empty_i,
   input  logic [FIFO_W-1:0]     fifo_data_i,
   output logic                  fifo_rd_o,
   output logic                  mem_req_valid_o,
   input  logic                  mem_req_ready_i,
   output logic                  mem_req_we_o,
   output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
   output logic [DATA_WIDTH-1:0] mem_req_wdata_o,
   output logic [DATA_BYTES-1:0] mem_req_strb_o,
   input  logic                  mem_rsp_valid_i,
   input  logic [DATA_WIDTH-1:0] mem_rsp_rdata_i,
   output logic                  fill_valid_o,
   output logic                  cpu_rvalid_o,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic [RSP_CNT_W-1:0]  rd_pending_o,
   output logic                  busy_o,
   output logic                  err_o
);

   localparam logic [RSP_CNT_W:0] DEPTH_LIM = (RSP_CNT_W + 1)'(RD_DEPTH);

   drain_state_e          state_reg;
   logic                  req_valid_reg;
   logic                  req_we_reg;
   logic                  req_load_reg;
   logic [ADDR_WIDTH-1:0] req_addr_reg;
   logic [DATA_WIDTH-1:0] req_wdata_reg;
   logic [DATA_BYTES-1:0] req_strb_reg;
   logic                  fill_valid_reg;
   logic                  cpu_rvalid_reg;
   logic [DATA_WIDTH-1:0] rdata_reg;
   logic [RSP_CNT_W-1:0]  rd_pending_reg;
   logic                  err_reg;

   cache_entry_t          head;
   logic                  q_head_load;
   logic                  q_empty;
   logic                  q_full;
   logic                  req_hs;
   logic                  rd_hs;
   logic                  rsp_ok;
   logic                  slot_avail;
   logic                  pop;
   logic [RSP_CNT_W:0]    pending_eff;

   assign head.load = fifo_data_i[LOAD_LSB];
   assign head.mode = fifo_data_i[MODE_LSB];
   assign head.strb = fifo_data_i[STRB_MSB:STRB_LSB];
   assign head.data = fifo_data_i[DATA_MSB:DATA_LSB];
   assign head.addr = fifo_data_i[ADDR_MSB:ADDR_LSB];

   assign req_hs = req_valid_reg && mem_req_ready_i;
   assign rd_hs  = req_hs && !req_we_reg;
   assign rsp_ok = mem_rsp_valid_i && !q_empty;

   // Reads in flight after this cycle, counting a read issued right now.
   assign pending_eff = {1'b0, rd_pending_reg}
                      + {{RSP_CNT_W{1'b0}}, rd_hs}
                      - {{RSP_CNT_W{1'b0}}, rsp_ok};
   assign slot_avail  = head.mode || ((pending_eff < DEPTH_LIM) && (!q_full || rsp_ok));

   assign pop = rst_ni && !fifo_empty_i && slot_avail
             && ((state_reg != DRAIN_REQ) || req_hs);

   assign fifo_rd_o       = pop;
   assign mem_req_valid_o = req_valid_reg;
   assign mem_req_we_o    = req_we_reg;
   assign mem_req_addr_o  = req_addr_reg;
   assign mem_req_wdata_o = req_wdata_reg;
   assign mem_req_strb_o  = req_strb_reg;
   assign fill_valid_o    = fill_valid_reg;
   assign cpu_rvalid_o    = cpu_rvalid_reg;
   assign rdata_o         = rdata_reg;
   assign rd_pending_o    = rd_pending_reg;
   assign busy_o          = req_valid_reg || (rd_pending_reg != '0);
   assign err_o           = err_reg;

   cache_tag_queue #(
      .DEPTH (RD_DEPTH),
      .PTR_W (CPU_ADDR_BUF)
   ) u_tag_queue (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .push_i     (rd_hs),
      .push_bit_i (req_load_reg),
      .pop_i      (mem_rsp_valid_i),
      .head_bit_o (q_head_load),
      .empty_o    (q_empty),
      .full_o     (q_full)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg      <= DRAIN_IDLE;
         req_valid_reg  <= 1'b0;
         req_we_reg     <= 1'b0;
         req_load_reg   <= 1'b0;
         req_addr_reg   <= '0;
         req_wdata_reg  <= '0;
         req_strb_reg   <= '0;
         fill_valid_reg <= 1'b0;
         cpu_rvalid_reg <= 1'b0;
         rdata_reg      <= '0;
         rd_pending_reg <= '0;
         err_reg        <= 1'b0;
      end else begin
         case (state_reg)
            DRAIN_IDLE: begin
               if (pop)                state_reg <= DRAIN_REQ;
               else if (!fifo_empty_i) state_reg <= DRAIN_STALL;
            end
            DRAIN_REQ: begin
               if (req_hs && !pop) state_reg <= DRAIN_IDLE;
            end
            DRAIN_STALL: begin
               if (pop)               state_reg <= DRAIN_REQ;
               else if (fifo_empty_i) state_reg <= DRAIN_IDLE;
            end
            default: state_reg <= DRAIN_IDLE;
         endcase

         // Request fields only change on a pop, so they hold through backpressure.
         if (pop) begin
            req_valid_reg <= 1'b1;
            req_we_reg    <= head.mode;
            req_load_reg  <= head.load;
            req_addr_reg  <= head.addr;
            req_wdata_reg <= head.data;
            req_strb_reg  <= head.mode ? head.strb : {DATA_BYTES{1'b1}};
         end else if (req_hs) begin
            req_valid_reg <= 1'b0;
         end

         if (rd_hs && !rsp_ok)      rd_pending_reg <= rd_pending_reg + RSP_CNT_W'(1);
         else if (rsp_ok && !rd_hs) rd_pending_reg <= rd_pending_reg - RSP_CNT_W'(1);

         fill_valid_reg <= rsp_ok && q_head_load;
         cpu_rvalid_reg <= rsp_ok && !q_head_load;
         if (rsp_ok) rdata_reg <= mem_rsp_rdata_i;
         if (mem_rsp_valid_i && q_empty) err_reg <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cache_mem_drain.sv
// Directed bench for cache_mem_drain: a FWFT FIFO model feeds entries and each
// task drives one scenario with hand-computed expectations.
module tb_cache_mem_drain;
   import cache_pkg::*;

   logic                     clk_i = 1'b0;
   logic                     rst_ni = 1'b0;
   logic                     fifo_empty_i;
   logic [FIFO_WIDTH_EX-1:0] fifo_data_i;
   logic                     fifo_rd_o;
   logic                     mem_req_valid_o;
   logic                     mem_req_ready_i = 1'b0;
   logic                     mem_req_we_o;
   logic [ADDR_WIDTH-1:0]    mem_req_addr_o;
   logic [DATA_WIDTH-1:0]    mem_req_wdata_o;
   logic [DATA_BYTES-1:0]    mem_req_strb_o;
   logic                     mem_rsp_valid_i = 1'b0;
   logic [DATA_WIDTH-1:0]    mem_rsp_rdata_i = '0;
   logic                     fill_valid_o;
   logic                     cpu_rvalid_o;
   logic [DATA_WIDTH-1:0]    rdata_o;
   logic [RSP_CNT_W-1:0]     rd_pending_o;
   logic                     busy_o;
   logic                     err_o;

   int vec_cnt  = 0;
   int miss_cnt = 0;
   int pop_cnt  = 0;
   int hs_cnt   = 0;
   int p0, h0;

   cache_entry_t fmem [16];
   logic [3:0]   fh = 4'd0;
   logic [3:0]   ft = 4'd0;

   always #5 clk_i = ~clk_i;

   assign fifo_empty_i = (fh == ft);
   assign fifo_data_i  = fmem[fh];

   cache_mem_drain dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .fifo_empty_i    (fifo_empty_i),
      .fifo_data_i     (fifo_data_i),
      .fifo_rd_o       (fifo_rd_o),
      .mem_req_valid_o (mem_req_valid_o),
      .mem_req_ready_i (mem_req_ready_i),
      .mem_req_we_o    (mem_req_we_o),
      .mem_req_addr_o  (mem_req_addr_o),
      .mem_req_wdata_o (mem_req_wdata_o),
      .mem_req_strb_o  (mem_req_strb_o),
      .mem_rsp_valid_i (mem_rsp_valid_i),
      .mem_rsp_rdata_i (mem_rsp_rdata_i),
      .fill_valid_o    (fill_valid_o),
      .cpu_rvalid_o    (cpu_rvalid_o),
      .rdata_o         (rdata_o),
      .rd_pending_o    (rd_pending_o),
      .busy_o          (busy_o),
      .err_o           (err_o)
   );

   always @(posedge clk_i) begin
      if (fifo_rd_o) begin
         fh      <= fh + 4'd1;
         pop_cnt <= pop_cnt + 1;
      end
      if (rst_ni && mem_req_valid_o && mem_req_ready_i) begin
         hs_cnt <= hs_cnt + 1;
         $display("txn req: we=%0b addr=%h wdata=%h strb=%h",
                  mem_req_we_o, mem_req_addr_o, mem_req_wdata_o, mem_req_strb_o);
      end
      if (fill_valid_o || cpu_rvalid_o)
         $display("txn rsp: fill=%0b cpu=%0b rdata=%h", fill_valid_o, cpu_rvalid_o, rdata_o);
   end

   function automatic cache_entry_t mk(input logic load, input logic mode,
                                       input logic [DATA_BYTES-1:0] strb,
                                       input logic [DATA_WIDTH-1:0] data,
                                       input logic [ADDR_WIDTH-1:0] addr);
      cache_entry_t e;
      e.load = load;
      e.mode = mode;
      e.strb = strb;
      e.data = data;
      e.addr = addr;
      return e;
   endfunction

   task automatic push(input cache_entry_t e);
      fmem[ft] = e;
      ft = ft + 4'd1;
   endtask

   task automatic test_reset;
      rst_ni = 1'b0;
      push(mk(1'b0, 1'b1, 4'hF, 32'h1, 32'h4));
      repeat (2) @(negedge clk_i);
      #1;
      vec_cnt++; if (fifo_rd_o !== 1'b0) begin miss_cnt++; $display("FAIL rst_fifo_rd: got %b want 0", fifo_rd_o); end
      vec_cnt++; if (mem_req_valid_o !== 1'b0 || mem_req_we_o !== 1'b0) begin miss_cnt++; $display("FAIL rst_valid_we: got %b/%b want 0/0", mem_req_valid_o, mem_req_we_o); end
      vec_cnt++; if (mem_req_addr_o !== '0 || mem_req_wdata_o !== '0 || mem_req_strb_o !== '0) begin miss_cnt++; $display("FAIL rst_fields: got %h/%h/%h want 0", mem_req_addr_o, mem_req_wdata_o, mem_req_strb_o); end
      vec_cnt++; if (fill_valid_o !== 1'b0 || cpu_rvalid_o !== 1'b0 || rdata_o !== '0) begin miss_cnt++; $display("FAIL rst_rsp: got %b/%b/%h want 0", fill_valid_o, cpu_rvalid_o, rdata_o); end
      vec_cnt++; if (rd_pending_o !== '0 || busy_o !== 1'b0 || err_o !== 1'b0) begin miss_cnt++; $display("FAIL rst_status: got %0d/%b/%b want 0", rd_pending_o, busy_o, err_o); end
      vec_cnt++; if (dut.state_reg !== DRAIN_IDLE) begin miss_cnt++; $display("FAIL rst_state: got %0d want %0d", dut.state_reg, DRAIN_IDLE); end
      ft = fh;
      @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   task automatic test_single_write;
      @(negedge clk_i);
      mem_req_ready_i = 1'b1;
      p0 = pop_cnt;
      push(mk(1'b0, 1'b1, 4'h3, 32'hDEADBEEF, 32'h100));
      #1;
      vec_cnt++; if (fifo_rd_o !== 1'b1) begin miss_cnt++; $display("FAIL wr_pop: got %b want 1", fifo_rd_o); end
      @(negedge clk_i);
      vec_cnt++; if (mem_req_valid_o !== 1'b1 || mem_req_we_o !== 1'b1) begin miss_cnt++; $display("FAIL wr_valid_we: got %b/%b want 1/1", mem_req_valid_o, mem_req_we_o); end
      vec_cnt++; if (mem_req_addr_o !== 32'h100 || mem_req_wdata_o !== 32'hDEADBEEF || mem_req_strb_o !== 4'h3) begin miss_cnt++; $display("FAIL wr_fields: got %h/%h/%h want 100/deadbeef/3", mem_req_addr_o, mem_req_wdata_o, mem_req_strb_o); end
      vec_cnt++; if (fifo_rd_o !== 1'b0) begin miss_cnt++; $display("FAIL wr_no_repop: got %b want 0", fifo_rd_o); end
      @(negedge clk_i);
      vec_cnt++; if (mem_req_valid_o !== 1'b0 || busy_o !== 1'b0) begin miss_cnt++; $display("FAIL wr_done: got valid=%b busy=%b want 0/0", mem_req_valid_o, busy_o); end
      vec_cnt++; if (pop_cnt - p0 !== 1) begin miss_cnt++; $display("FAIL wr_pop_count: got %0d want 1", pop_cnt - p0); end
   endtask

   task automatic test_backpressure;
      logic [ADDR_WIDTH-1:0] exp_addr [3];
      exp_addr[0] = 32'h200;
      exp_addr[1] = 32'h204;
      exp_addr[2] = 32'h208;
      @(negedge clk_i);
      mem_req_ready_i = 1'b0;
      p0 = pop_cnt;
      h0 = hs_cnt;
      for (int i = 0; i < 3; i++) push(mk(1'b0, 1'b1, 4'hF, 32'hA0 + i, exp_addr[i]));
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_i);
         #1;
         vec_cnt++; if (mem_req_valid_o !== 1'b1 || mem_req_addr_o !== 32'h200 || mem_req_wdata_o !== 32'hA0 || fifo_rd_o !== 1'b0) begin
            miss_cnt++; $display("FAIL bp_hold[%0d]: got valid=%b addr=%h wdata=%h pop=%b want 1/200/a0/0", i, mem_req_valid_o, mem_req_addr_o, mem_req_wdata_o, fifo_rd_o); end
      end
      vec_cnt++; if (pop_cnt - p0 !== 1) begin miss_cnt++; $display("FAIL bp_pop_count: got %0d want 1", pop_cnt - p0); end
      mem_req_ready_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         vec_cnt++; if (mem_req_valid_o !== 1'b1 || mem_req_addr_o !== exp_addr[i]) begin miss_cnt++; $display("FAIL bp_b2b[%0d]: got valid=%b addr=%h want 1/%h", i, mem_req_valid_o, mem_req_addr_o, exp_addr[i]); end
         @(negedge clk_i);
      end
      vec_cnt++; if (mem_req_valid_o !== 1'b0 || hs_cnt - h0 !== 3) begin miss_cnt++; $display("FAIL bp_hs_count: got valid=%b hs=%0d want 0/3", mem_req_valid_o, hs_cnt - h0); end
   endtask

   task automatic test_read_routing;
      @(negedge clk_i);
      mem_req_ready_i = 1'b1;
      push(mk(1'b1, 1'b0, 4'h0, 32'h0, 32'h40));
      push(mk(1'b0, 1'b0, 4'h0, 32'h0, 32'h44));
      @(negedge clk_i);
      vec_cnt++; if (mem_req_valid_o !== 1'b1 || mem_req_we_o !== 1'b0 || mem_req_strb_o !== 4'hF || mem_req_addr_o !== 32'h40) begin
         miss_cnt++; $display("FAIL rd_req0: got valid=%b we=%b strb=%h addr=%h want 1/0/f/40", mem_req_valid_o, mem_req_we_o, mem_req_strb_o, mem_req_addr_o); end
      @(negedge clk_i);
      vec_cnt++; if (mem_req_addr_o !== 32'h44 || mem_req_strb_o !== 4'hF) begin miss_cnt++; $display("FAIL rd_req1: got addr=%h strb=%h want 44/f", mem_req_addr_o, mem_req_strb_o); end
      @(negedge clk_i);
      vec_cnt++; if (mem_req_valid_o !== 1'b0 || rd_pending_o !== 3'd2 || busy_o !== 1'b1) begin miss_cnt++; $display("FAIL rd_pending: got valid=%b pend=%0d busy=%b want 0/2/1", mem_req_valid_o, rd_pending_o, busy_o); end
      mem_rsp_valid_i = 1'b1;
      mem_rsp_rdata_i = 32'h11;
      @(negedge clk_i);
      mem_rsp_rdata_i = 32'h22;
      vec_cnt++; if (fill_valid_o !== 1'b1 || cpu_rvalid_o !== 1'b0 || rdata_o !== 32'h11) begin miss_cnt++; $display("FAIL rd_fill: got fill=%b cpu=%b rdata=%h want 1/0/11", fill_valid_o, cpu_rvalid_o, rdata_o); end
      @(negedge clk_i);
      mem_rsp_valid_i = 1'b0;
      vec_cnt++; if (fill_valid_o !== 1'b0 || cpu_rvalid_o !== 1'b1 || rdata_o !== 32'h22) begin miss_cnt++; $display("FAIL rd_cpu: got fill=%b cpu=%b rdata=%h want 0/1/22", fill_valid_o, cpu_rvalid_o, rdata_o); end
      @(negedge clk_i);
      vec_cnt++; if (fill_valid_o !== 1'b0 || cpu_rvalid_o !== 1'b0 || rd_pending_o !== '0) begin miss_cnt++; $display("FAIL rd_quiet: got fill=%b cpu=%b pend=%0d want 0/0/0", fill_valid_o, cpu_rvalid_o, rd_pending_o); end
   endtask

   task automatic test_slot_limit;
      logic exp_load;
      @(negedge clk_i);
      mem_req_ready_i = 1'b1;
      p0 = pop_cnt;
      h0 = hs_cnt;
      for (int i = 0; i < 5; i++) push(mk((i % 2) == 1, 1'b0, 4'h0, 32'h0, 32'h300 + 4 * i));
      repeat (7) @(negedge clk_i);
      #1;
      vec_cnt++; if (hs_cnt - h0 !== 4 || pop_cnt - p0 !== 4) begin miss_cnt++; $display("FAIL slot_counts: got hs=%0d pops=%0d want 4/4", hs_cnt - h0, pop_cnt - p0); end
      vec_cnt++; if (rd_pending_o !== 3'd4 || mem_req_valid_o !== 1'b0 || fifo_rd_o !== 1'b0) begin miss_cnt++; $display("FAIL slot_full: got pend=%0d valid=%b pop=%b want 4/0/0", rd_pending_o, mem_req_valid_o, fifo_rd_o); end
      vec_cnt++; if (dut.state_reg !== DRAIN_STALL) begin miss_cnt++; $display("FAIL slot_stall: got state %0d want %0d", dut.state_reg, DRAIN_STALL); end
      mem_rsp_valid_i = 1'b1;
      mem_rsp_rdata_i = 32'h1000;
      #1;
      vec_cnt++; if (fifo_rd_o !== 1'b1) begin miss_cnt++; $display("FAIL slot_release_pop: got %b want 1", fifo_rd_o); end
      @(negedge clk_i);
      mem_rsp_valid_i = 1'b0;
      vec_cnt++; if (cpu_rvalid_o !== 1'b1 || rdata_o !== 32'h1000 || mem_req_valid_o !== 1'b1 || mem_req_addr_o !== 32'h310 || rd_pending_o !== 3'd3) begin
         miss_cnt++; $display("FAIL slot_release: got cpu=%b rdata=%h valid=%b addr=%h pend=%0d want 1/1000/1/310/3", cpu_rvalid_o, rdata_o, mem_req_valid_o, mem_req_addr_o, rd_pending_o); end
      @(negedge clk_i);
      vec_cnt++; if (rd_pending_o !== 3'd4 || mem_req_valid_o !== 1'b0) begin miss_cnt++; $display("FAIL slot_refill: got pend=%0d valid=%b want 4/0", rd_pending_o, mem_req_valid_o); end
      for (int i = 1; i < 5; i++) begin
         exp_load = ((i % 2) == 1);
         mem_rsp_valid_i = 1'b1;
         mem_rsp_rdata_i = 32'h1000 + i;
         @(negedge clk_i);
         vec_cnt++; if (fill_valid_o !== exp_load || cpu_rvalid_o !== !exp_load || rdata_o !== 32'h1000 + i) begin
            miss_cnt++; $display("FAIL slot_drain[%0d]: got fill=%b cpu=%b rdata=%h want %b/%b/%h", i, fill_valid_o, cpu_rvalid_o, rdata_o, exp_load, !exp_load, 32'h1000 + i); end
      end
      mem_rsp_valid_i = 1'b0;
      @(negedge clk_i);
      vec_cnt++; if (rd_pending_o !== '0 || busy_o !== 1'b0) begin miss_cnt++; $display("FAIL slot_empty: got pend=%0d busy=%b want 0/0", rd_pending_o, busy_o); end
   endtask

   task automatic test_back_to_back;
      @(negedge clk_i);
      mem_req_ready_i = 1'b1;
      push(mk(1'b1, 1'b0, 4'h0, 32'h0, 32'h500));
      push(mk(1'b0, 1'b0, 4'h0, 32'h0, 32'h504));
      repeat (3) @(negedge clk_i);
      vec_cnt++; if (rd_pending_o !== 3'd2) begin miss_cnt++; $display("FAIL sim_pend2: got %0d want 2", rd_pending_o); end
      mem_req_ready_i = 1'b0;
      push(mk(1'b1, 1'b0, 4'h0, 32'h0, 32'h508));
      @(negedge clk_i);
      vec_cnt++; if (mem_req_valid_o !== 1'b1 || mem_req_addr_o !== 32'h508) begin miss_cnt++; $display("FAIL sim_held: got valid=%b addr=%h want 1/508", mem_req_valid_o, mem_req_addr_o); end
      mem_req_ready_i = 1'b1;
      mem_rsp_valid_i = 1'b1;
      mem_rsp_rdata_i = 32'hAA;
      @(negedge clk_i);
      mem_rsp_rdata_i = 32'hBB;
      vec_cnt++; if (rd_pending_o !== 3'd2 || fill_valid_o !== 1'b1 || rdata_o !== 32'hAA || mem_req_valid_o !== 1'b0) begin
         miss_cnt++; $display("FAIL sim_both: got pend=%0d fill=%b rdata=%h valid=%b want 2/1/aa/0", rd_pending_o, fill_valid_o, rdata_o, mem_req_valid_o); end
      @(negedge clk_i);
      mem_rsp_rdata_i = 32'hCC;
      vec_cnt++; if (cpu_rvalid_o !== 1'b1 || fill_valid_o !== 1'b0 || rdata_o !== 32'hBB || rd_pending_o !== 3'd1) begin
         miss_cnt++; $display("FAIL sim_order_b: got cpu=%b fill=%b rdata=%h pend=%0d want 1/0/bb/1", cpu_rvalid_o, fill_valid_o, rdata_o, rd_pending_o); end
      @(negedge clk_i);
      mem_rsp_valid_i = 1'b0;
      vec_cnt++; if (fill_valid_o !== 1'b1 || cpu_rvalid_o !== 1'b0 || rdata_o !== 32'hCC || rd_pending_o !== '0) begin
         miss_cnt++; $display("FAIL sim_order_c: got fill=%b cpu=%b rdata=%h pend=%0d want 1/0/cc/0", fill_valid_o, cpu_rvalid_o, rdata_o, rd_pending_o); end
   endtask

   task automatic test_faults;
      @(negedge clk_i);
      mem_rsp_valid_i = 1'b1;
      mem_rsp_rdata_i = 32'h77;
      @(negedge clk_i);
      mem_rsp_valid_i = 1'b0;
      vec_cnt++; if (fill_valid_o !== 1'b0 || cpu_rvalid_o !== 1'b0 || err_o !== 1'b1 || rd_pending_o !== '0 || rdata_o !== 32'hCC) begin
         miss_cnt++; $display("FAIL flt_unexp: got fill=%b cpu=%b err=%b pend=%0d rdata=%h want 0/0/1/0/cc", fill_valid_o, cpu_rvalid_o, err_o, rd_pending_o, rdata_o); end
      repeat (3) @(negedge clk_i);
      vec_cnt++; if (err_o !== 1'b1) begin miss_cnt++; $display("FAIL flt_sticky: got %b want 1", err_o); end
      mem_req_ready_i = 1'b1;
      push(mk(1'b1, 1'b0, 4'h0, 32'h0, 32'h600));
      push(mk(1'b0, 1'b1, 4'h1, 32'h5, 32'h604));
      repeat (2) @(negedge clk_i);
      mem_req_ready_i = 1'b0;
      vec_cnt++; if (mem_req_valid_o !== 1'b1 || mem_req_addr_o !== 32'h604 || rd_pending_o !== 3'd1) begin
         miss_cnt++; $display("FAIL flt_pre_rst: got valid=%b addr=%h pend=%0d want 1/604/1", mem_req_valid_o, mem_req_addr_o, rd_pending_o); end
      #2;
      rst_ni = 1'b0;
      #1;
      vec_cnt++; if (mem_req_valid_o !== 1'b0 || rd_pending_o !== '0 || busy_o !== 1'b0 || err_o !== 1'b0 || fifo_rd_o !== 1'b0) begin
         miss_cnt++; $display("FAIL flt_async_rst: got valid=%b pend=%0d busy=%b err=%b pop=%b want 0", mem_req_valid_o, rd_pending_o, busy_o, err_o, fifo_rd_o); end
      ft = fh;
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      mem_rsp_valid_i = 1'b1;
      mem_rsp_rdata_i = 32'h99;
      @(negedge clk_i);
      mem_rsp_valid_i = 1'b0;
      vec_cnt++; if (err_o !== 1'b1 || fill_valid_o !== 1'b0 || cpu_rvalid_o !== 1'b0 || rd_pending_o !== '0) begin
         miss_cnt++; $display("FAIL flt_inflight: got err=%b fill=%b cpu=%b pend=%0d want 1/0/0/0", err_o, fill_valid_o, cpu_rvalid_o, rd_pending_o); end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) fmem[i] = '0;
      test_reset();
      test_single_write();
      test_backpressure();
      test_read_routing();
      test_slot_limit();
      test_back_to_back();
      test_faults();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
